b3_binary_window_rx: RTL and testbench

//  - Receiving end of the Block2 binary output stream: 16 thresholded bits per valid strobe.
//  - Collects successive vectors into a sliding K-tap window.
//  - Presents one CH*K-bit window per output strobe to the Block3 XNOR/popcount conv array.
//  - Frame-based: frame_start opens a sequence of FRAME_LEN input vectors; frame_done closes it.

---
 rtl/b3_pkg.sv | 20 ++
 rtl/bin_shift_window.sv | 40 ++++
 rtl/b3_binary_window_rx.sv | 184 ++++++++++++++++++
 tb/tb_b3_binary_window_rx.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/b3_pkg.sv
// Shared constants for the Block3 binary window receiver.
//   B3_CH        binary channels per input vector
//   B3_K         window taps (kernel length, odd)
//   B3_FRAME_LEN input vectors per frame
//   B3_CNT_W     counter width, 2**B3_CNT_W must exceed B3_FRAME_LEN + (B3_K-1)/2
//   ST_IDLE..ST_DONE  3-bit FSM encoding of the receiver
package b3_pkg;

  localparam int B3_CH        = 16;
  localparam int B3_K         = 7;
  localparam int B3_FRAME_LEN = 320;
  localparam int B3_CNT_W     = 9;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_FILL = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam logic [2:0] ST_TAIL = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

endpackage

// File: rtl/bin_shift_window.sv
// CH-wide, K-deep shift register holding the sliding window.
// Tap t lives at [t*CH +: CH]; tap 0 is the oldest, tap K-1 the newest.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clr          clear all taps to zero (has priority over shift)
//   shift_en     shift one vector in at tap K-1, taps move toward 0
//   zero_ld      when shifting, insert an all-zero vector instead of din
//   din          vector to shift in
//   win_shifted  combinational view of the window as it will be after a shift
module bin_shift_window #(
  parameter int CH = 16,
  parameter int K  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift_en,
  input  logic              zero_ld,
  input  logic [CH-1:0]     din,
  output logic [CH*K-1:0]   win_shifted
);

  logic [CH*K-1:0] win_q;
  logic [CH-1:0]   shift_in;

  assign shift_in    = zero_ld ? '0 : din;
  // Drop tap 0, move every tap down by one, newest vector lands at the top.
  assign win_shifted = {shift_in, win_q[CH*K-1:CH]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q <= '0;
    end else if (clr) begin
      win_q <= '0;
    end else if (shift_en) begin
      win_q <= win_shifted;
    end
  end

endmodule

// File: rtl/b3_binary_window_rx.sv
// Receiving end of the Block2 binary stream. Collects CH-bit vectors into a
// K-tap sliding window and emits one CH*K-bit window per strobe towards the
// Block3 XNOR/popcount array. Frames are opened by frame_start and span
// FRAME_LEN input vectors.
//
// Build option B3_SAME_PAD_EN: "same" padding. The window starts with
// (K-1)/2 zero taps already in place and a TAIL phase shifts in (K-1)/2 zero
// vectors after the last input, giving FRAME_LEN windows per frame. Without
// it the design is a "valid" convolution front end: FRAME_LEN-K+1 windows.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   frame_start   1-cycle pulse, (re)opens a frame from any state
//   bin_in        binary vector, bit c = channel c
//   bin_in_val    bin_in valid
//   win_out       window, tap t at [t*CH +: CH], t=0 oldest
//   win_val       win_out/win_idx valid for one cycle
//   win_idx       window index inside the frame, from 0
//   frame_done    1-cycle pulse the cycle after the last window of a frame
//   err_unexp     1-cycle pulse: bin_in_val arrived outside FILL/RUN
//   dbg_state     current FSM state (ST_* encoding)
//
// Handshake: there is no ready. A vector is taken on every rising edge where
// bin_in_val is high in FILL/RUN and frame_start is low; win_val is high for
// exactly one cycle per window, the cycle after the edge that produced it,
// and the consumer must take every window.
module b3_binary_window_rx
  import b3_pkg::*;
#(
  parameter int CH        = B3_CH,
  parameter int K         = B3_K,
  parameter int FRAME_LEN = B3_FRAME_LEN,
  parameter int CNT_W     = B3_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic [CH-1:0]      bin_in,
  input  logic               bin_in_val,
  output logic [CH*K-1:0]    win_out,
  output logic               win_val,
  output logic [CNT_W-1:0]   win_idx,
  output logic               frame_done,
  output logic               err_unexp,
  output logic [2:0]         dbg_state
);

`ifdef B3_SAME_PAD_EN
  localparam int         PAD    = (K - 1) / 2;
  localparam logic [2:0] END_ST = ST_TAIL;
  // in_cnt keeps counting through the zero injections of TAIL.
  localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(FRAME_LEN + PAD - 1);
`else
  localparam int         PAD    = 0;
  localparam logic [2:0] END_ST = ST_DONE;
`endif

  // Preloaded zero taps mean only K-PAD real samples complete the first window.
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(K - PAD - 1);
  localparam logic [CNT_W-1:0] LAST_IN   = CNT_W'(FRAME_LEN - 1);

  logic [2:0]        state, state_nxt;
  logic [CNT_W-1:0]  in_cnt;
  logic [CNT_W-1:0]  win_cnt;
  logic [CH*K-1:0]   win_shifted;

  logic win_clr, win_shift, win_zero;
  logic emit, cnt_inc, cnt_clr, err_nxt, done_nxt;

  // The preloaded zero taps of the padded build are simply the cleared
  // window: clearing on frame_start gives both variants the right start.
  bin_shift_window #(
    .CH (CH),
    .K  (K)
  ) u_win (
    .clk         (clk),
    .rst         (rst),
    .clr         (win_clr),
    .shift_en    (win_shift),
    .zero_ld     (win_zero),
    .din         (bin_in),
    .win_shifted (win_shifted)
  );

  always_comb begin
    state_nxt = state;
    win_clr   = 1'b0;
    win_shift = 1'b0;
    win_zero  = 1'b0;
    emit      = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    err_nxt   = 1'b0;
    done_nxt  = 1'b0;
    if (frame_start) begin
      // Restart wins over everything, including a sample in the same cycle.
      state_nxt = ST_FILL;
      win_clr   = 1'b1;
      cnt_clr   = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          err_nxt = bin_in_val;
        end
        ST_FILL: begin
          if (bin_in_val) begin
            win_shift = 1'b1;
            cnt_inc   = 1'b1;
            if (in_cnt == FILL_LAST) begin
              emit      = 1'b1;
              state_nxt = (in_cnt == LAST_IN) ? END_ST : ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (bin_in_val) begin
            win_shift = 1'b1;
            cnt_inc   = 1'b1;
            emit      = 1'b1;
            if (in_cnt == LAST_IN) begin
              state_nxt = END_ST;
            end
          end
        end
`ifdef B3_SAME_PAD_EN
        ST_TAIL: begin
          err_nxt   = bin_in_val;
          win_shift = 1'b1;
          win_zero  = 1'b1;
          emit      = 1'b1;
          cnt_inc   = 1'b1;
          if (in_cnt == TAIL_LAST) begin
            state_nxt = ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          err_nxt   = bin_in_val;
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      in_cnt     <= '0;
      win_cnt    <= '0;
      win_out    <= '0;
      win_val    <= 1'b0;
      win_idx    <= '0;
      frame_done <= 1'b0;
      err_unexp  <= 1'b0;
    end else begin
      state      <= state_nxt;
      win_val    <= emit;
      frame_done <= done_nxt;
      err_unexp  <= err_nxt;
      if (cnt_clr) begin
        in_cnt  <= '0;
        win_cnt <= '0;
        win_idx <= '0;
        win_out <= '0;
      end else begin
        if (cnt_inc) begin
          in_cnt <= in_cnt + CNT_W'(1);
        end
        if (emit) begin
          win_out <= win_shifted;
          win_idx <= win_cnt;
          win_cnt <= win_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_b3_binary_window_rx.sv
module tb_b3_binary_window_rx;
  import b3_pkg::*;

  localparam int CH    = 16;
  localparam int K     = 7;
  localparam int FL    = 10;
  localparam int CNT_W = 9;
  localparam int W     = CH * K;
`ifdef B3_SAME_PAD_EN
  localparam int PAD = (K - 1) / 2;
  localparam int NW  = FL;
`else
  localparam int PAD = 0;
  localparam int NW  = FL - K + 1;
`endif

  logic             clk;
  logic             rst;
  logic             frame_start;
  logic [CH-1:0]    bin_in;
  logic             bin_in_val;
  logic [W-1:0]     win_out;
  logic             win_val;
  logic [CNT_W-1:0] win_idx;
  logic             frame_done;
  logic             err_unexp;
  logic [2:0]       dbg_state;

  b3_binary_window_rx #(
    .CH        (CH),
    .K         (K),
    .FRAME_LEN (FL),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .bin_in      (bin_in),
    .bin_in_val  (bin_in_val),
    .win_out     (win_out),
    .win_val     (win_val),
    .win_idx     (win_idx),
    .frame_done  (frame_done),
    .err_unexp   (err_unexp),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  int n_chk = 0;
  int n_err = 0;

  logic [W-1:0]     exp_q[$];
  logic [W-1:0]     cap_win[$];
  logic [CNT_W-1:0] cap_idx[$];
  int done_cnt, err_cnt, spur_cnt, done_cyc, last_win_cyc;
  logic acc_edge = 1'b0;
  logic [CH-1:0] smp[FL];

  typedef struct {
    logic [CNT_W-1:0] idx;
    logic [CH-1:0]    tap0;
    logic [CH-1:0]    tap_new;
  } vec_t;
  vec_t tbl[NW];

  // Remember whether each edge offered a sample, to flag windows from nowhere.
  always @(posedge clk) acc_edge = bin_in_val && !frame_start;

  always @(negedge clk) begin
    if (win_val) begin
      cap_win.push_back(win_out);
      cap_idx.push_back(win_idx);
      last_win_cyc = cyc;
`ifndef B3_SAME_PAD_EN
      if (!acc_edge) spur_cnt++;
`endif
    end
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (err_unexp) err_cnt++;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: window w, tap t sees sample w+t-PAD, zero outside the frame.
  function automatic logic [W-1:0] exp_win(int w);
    logic [W-1:0] r;
    r = '0;
    for (int t = 0; t < K; t++) begin
      int s;
      s = w + t - PAD;
      if (s >= 0 && s < FL) r[t*CH +: CH] = smp[s];
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    cap_win.delete();
    cap_idx.delete();
    exp_q.delete();
    done_cnt = 0;
    err_cnt  = 0;
    spur_cnt = 0;
    done_cyc = 0;
    last_win_cyc = 0;
  endtask

  task automatic send(input logic [CH-1:0] v, input int gap);
    bin_in     = v;
    bin_in_val = 1'b1;
    step();
    bin_in_val = 1'b0;
    repeat (gap) step();
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic send_frame(input int max_gap);
    for (int n = 0; n < FL; n++) send(smp[n], $urandom_range(max_gap, 0));
  endtask

  task automatic check_frame(input string tag);
    for (int i = 0; i < NW; i++) exp_q.push_back(exp_win(i));
    chk({tag, " win_count"}, 128'(cap_win.size()), 128'(NW));
    for (int i = 0; i < NW; i++) begin
      if (i < cap_win.size()) begin
        chk($sformatf("%s win%0d", tag, i), 128'(cap_win[i]), 128'(exp_q[i]));
        chk($sformatf("%s idx%0d", tag, i), 128'(cap_idx[i]), 128'(i));
      end
    end
    chk({tag, " done_cnt"}, 128'(done_cnt), 128'(1));
    chk({tag, " done_lag"}, 128'(done_cyc - last_win_cyc), 128'(1));
    chk({tag, " spurious_win"}, 128'(spur_cnt), 128'(0));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1;
    frame_start = 1'b0;
    bin_in = '0;
    bin_in_val = 1'b0;
    clear_mon();

    for (int i = 0; i < NW; i++) begin
      tbl[i].idx = CNT_W'(i);
`ifdef B3_SAME_PAD_EN
      tbl[i].tap0    = (i >= 3) ? CH'(1) << (i - 3) : '0;
      tbl[i].tap_new = (i <= 6) ? CH'(1) << (i + 3) : '0;
`else
      tbl[i].tap0    = CH'(1) << i;
      tbl[i].tap_new = CH'(1) << (i + 6);
`endif
    end

    repeat (3) step();
    // Reset state
    chk("rst win_val", 128'(win_val), 128'(0));
    chk("rst win_out", 128'(win_out), 128'(0));
    chk("rst win_idx", 128'(win_idx), 128'(0));
    chk("rst frame_done", 128'(frame_done), 128'(0));
    chk("rst err_unexp", 128'(err_unexp), 128'(0));
    chk("rst state", 128'(dbg_state), 128'(ST_IDLE));
    rst = 1'b0;
    step();

    // T1: one-hot walking samples back to back
    for (int n = 0; n < FL; n++) smp[n] = CH'(1) << n;
    clear_mon();
    start_frame();
    send_frame(0);
    repeat (8) step();
    check_frame("t1");
    for (int i = 0; i < NW; i++) begin
      if (i < cap_win.size()) begin
        chk($sformatf("t1 tbl_tap0_%0d", i), 128'(cap_win[i][CH-1:0]), 128'(tbl[i].tap0));
        chk($sformatf("t1 tbl_tapn_%0d", i), 128'(cap_win[i][W-1 -: CH]), 128'(tbl[i].tap_new));
        chk($sformatf("t1 tbl_idx_%0d", i), 128'(cap_idx[i]), 128'(tbl[i].idx));
      end
    end
`ifdef B3_SAME_PAD_EN
    if (cap_win.size() == NW) begin
      chk("t1 w0 taps0_3", 128'(cap_win[0][4*CH-1:0]), 128'(64'h0001_0000_0000_0000));
      chk("t1 wlast taps4_6", 128'(cap_win[NW-1][W-1:4*CH]), 128'(0));
    end
`endif
    chk("t1 err", 128'(err_cnt), 128'(0));
    chk("t1 state idle", 128'(dbg_state), 128'(ST_IDLE));

    // T2: random gaps of 0..3 cycles, same data
    clear_mon();
    start_frame();
    send_frame(3);
    repeat (8) step();
    check_frame("t2");

    // T3: abort after 5 samples, restart with fresh data
    clear_mon();
    start_frame();
    for (int n = 0; n < 5; n++) send(16'hA000 | CH'(n), 0);
    repeat (3) step();
    chk("t3 no_done_abort", 128'(done_cnt), 128'(0));
    for (int n = 0; n < FL; n++) smp[n] = 16'h0100 + CH'(n * 3);
    clear_mon();
    start_frame();
    send_frame(0);
    repeat (8) step();
    check_frame("t3");

    // T4: sample in IDLE, then restart with a sample in the same cycle,
    // then samples held on after the last input (TAIL or DONE/IDLE)
    clear_mon();
    send(16'hBEEF, 2);
    chk("t4 idle err", 128'(err_cnt), 128'(1));
    chk("t4 idle no_win", 128'(cap_win.size()), 128'(0));
    chk("t4 idle idx", 128'(win_idx), 128'(NW - 1));
    for (int n = 0; n < FL; n++) smp[n] = 16'h5A00 ^ CH'(n << 4);
    clear_mon();
    bin_in = 16'hFFFF;
    bin_in_val = 1'b1;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    bin_in_val = 1'b0;
    for (int n = 0; n < FL - 1; n++) send(smp[n], 0);
    bin_in = smp[FL-1];
    bin_in_val = 1'b1;
    step();
    bin_in = 16'hC3C3;
    repeat (2) step();
    bin_in_val = 1'b0;
    repeat (8) step();
    check_frame("t4");
    chk("t4 late err", 128'(err_cnt), 128'(2));

    // T5: async reset in the middle of RUN
    clear_mon();
    for (int n = 0; n < FL; n++) smp[n] = 16'h7000 | CH'(n);
    start_frame();
    for (int n = 0; n < 8; n++) send(smp[n], 0);
    rst = 1'b1;
    #1;
    chk("t5 rst win_val", 128'(win_val), 128'(0));
    chk("t5 rst win_out", 128'(win_out), 128'(0));
    chk("t5 rst win_idx", 128'(win_idx), 128'(0));
    chk("t5 rst state", 128'(dbg_state), 128'(ST_IDLE));
    step();
    rst = 1'b0;
    step();
    clear_mon();
    send(smp[8], 0);
    send(smp[9], 4);
    chk("t5 post err", 128'(err_cnt), 128'(2));
    chk("t5 post no_win", 128'(cap_win.size()), 128'(0));
    chk("t5 post no_done", 128'(done_cnt), 128'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
